// File: rtl/irda_mir_rx_data_ctrl.sv
// MIR receive data controller: packs de-stuffed bits LSB-first into 32-bit
// words and hands them to the RX FIFO through a one-word holding register.
module irda_mir_rx_data_ctrl (
    input  logic        clk,
    input  logic        wb_rst_i,
    input  logic        dc_restart,
    input  logic        mir_rx_enabled,
    input  logic        data_valid,
    input  logic        data_i,
    input  logic        frame_end,
    input  logic        rxfifo_full,
    output logic        rxfifo_add,
    output logic [31:0] rxfifo_dat_i,
    output logic        rx_last,
    output logic [5:0]  rx_last_bits,
    output logic        overrun
);

    logic [31:0] r_sr;
    logic [4:0]  r_cnt;
    logic [31:0] r_hold;
    logic        r_pending;
    logic        r_hold_last;
    logic [5:0]  r_hold_bits;

    logic        w_bit;
    logic        w_end;
    logic [31:0] w_sr_next;
    logic [5:0]  w_nbits;
    logic        w_word_done;
    logic        w_flush;
    logic        w_cand;
    logic [5:0]  w_cand_bits;
    logic        w_drain;
    logic        w_free;

    always_comb begin
        w_bit     = mir_rx_enabled & data_valid;
        w_end     = mir_rx_enabled & frame_end;
        w_sr_next = r_sr;
        if (w_bit) begin
            w_sr_next[r_cnt] = data_i;
        end
        w_nbits     = {1'b0, r_cnt} + {5'b0, w_bit};
        w_word_done = w_bit & (r_cnt == 5'd31);
        // A frame end with nothing collected produces no word at all
        w_flush     = w_end & (w_nbits != 6'd0);
        w_cand      = w_word_done | w_flush;
        w_cand_bits = w_flush ? w_nbits : 6'd32;
        w_drain     = r_pending & ~rxfifo_full;
        w_free      = ~r_pending | w_drain;
    end

    always_ff @(posedge clk) begin
        if (wb_rst_i || dc_restart) begin
            r_sr         <= 32'd0;
            r_cnt        <= 5'd0;
            r_hold       <= 32'd0;
            r_pending    <= 1'b0;
            r_hold_last  <= 1'b0;
            r_hold_bits  <= 6'd0;
            rxfifo_add   <= 1'b0;
            rxfifo_dat_i <= 32'd0;
            rx_last      <= 1'b0;
            rx_last_bits <= 6'd0;
            overrun      <= 1'b0;
        end else begin
            if (w_word_done || w_end) begin
                r_sr  <= 32'd0;
                r_cnt <= 5'd0;
            end else if (w_bit) begin
                r_sr  <= w_sr_next;
                r_cnt <= r_cnt + 5'd1;
            end

            if (w_drain) begin
                rxfifo_add   <= 1'b1;
                rxfifo_dat_i <= r_hold;
                rx_last      <= r_hold_last;
                rx_last_bits <= r_hold_bits;
                r_pending    <= 1'b0;
            end else begin
                rxfifo_add <= 1'b0;
                rx_last    <= 1'b0;
            end

            // Loading after the drain lets a same-edge load win over the clear
            if (w_cand) begin
                if (w_free) begin
                    r_hold      <= w_sr_next;
                    r_hold_last <= w_flush;
                    r_hold_bits <= w_cand_bits;
                    r_pending   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_irda_mir_rx_data_ctrl.sv
// Directed self-checking bench for irda_mir_rx_data_ctrl.
module tb_irda_mir_rx_data_ctrl;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        dc_restart = 1'b0;
    logic        mir_rx_enabled = 1'b1;
    logic        data_valid = 1'b0;
    logic        data_i = 1'b0;
    logic        frame_end = 1'b0;
    logic        rxfifo_full = 1'b0;
    logic        rxfifo_add;
    logic [31:0] rxfifo_dat_i;
    logic        rx_last;
    logic [5:0]  rx_last_bits;
    logic        overrun;

    int n_checks = 0;
    int n_fail = 0;
    int n_adds = 0;
    int base;

    irda_mir_rx_data_ctrl dut (
        .clk            (clk),
        .wb_rst_i       (wb_rst_i),
        .dc_restart     (dc_restart),
        .mir_rx_enabled (mir_rx_enabled),
        .data_valid     (data_valid),
        .data_i         (data_i),
        .frame_end      (frame_end),
        .rxfifo_full    (rxfifo_full),
        .rxfifo_add     (rxfifo_add),
        .rxfifo_dat_i   (rxfifo_dat_i),
        .rx_last        (rx_last),
        .rx_last_bits   (rx_last_bits),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rxfifo_add) n_adds <= n_adds + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_bits(input logic [31:0] w, input int n,
                             input logic fe_last);
        for (int i = 0; i < n; i++) begin
            data_valid = 1'b1;
            data_i     = w[i];
            frame_end  = fe_last && (i == n - 1);
            step();
        end
        data_valid = 1'b0;
        data_i     = 1'b0;
        frame_end  = 1'b0;
    endtask

    task automatic pulse_end();
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_add"}, {31'd0, rxfifo_add}, 32'd0);
        check({tag, "_dat"}, rxfifo_dat_i, 32'd0);
        check({tag, "_last"}, {31'd0, rx_last}, 32'd0);
        check({tag, "_bits"}, {26'd0, rx_last_bits}, 32'd0);
        check({tag, "_ovr"}, {31'd0, overrun}, 32'd0);
    endtask

    initial begin
        idle(2);
        wb_rst_i = 1'b0;
        check_zero("reset");

        // 1: full word, latency of two edges from last strobe
        send_bits(32'hA5C3_0F01, 32, 1'b0);
        check("t1_add_n1", {31'd0, rxfifo_add}, 32'd0);
        step();
        check("t1_add", {31'd0, rxfifo_add}, 32'd1);
        check("t1_dat", rxfifo_dat_i, 32'hA5C3_0F01);
        check("t1_last", {31'd0, rx_last}, 32'd0);
        step();
        check("t1_add_off", {31'd0, rxfifo_add}, 32'd0);

        // 2: partial word flush, then empty frame end and disabled input
        send_bits(32'h0000_0ABC, 12, 1'b0);
        pulse_end();
        step();
        check("t2_add", {31'd0, rxfifo_add}, 32'd1);
        check("t2_dat", rxfifo_dat_i, 32'h0000_0ABC);
        check("t2_last", {31'd0, rx_last}, 32'd1);
        check("t2_bits", {26'd0, rx_last_bits}, 32'd12);
        idle(2);
        base = n_adds;
        pulse_end();
        idle(3);
        check("t2_empty_end", n_adds - base, 0);
        mir_rx_enabled = 1'b0;
        send_bits(32'hFFFF_FFFF, 5, 1'b1);
        mir_rx_enabled = 1'b1;
        idle(3);
        check("t2_disabled_adds", n_adds - base, 0);
        check("t2_disabled_cnt", {27'd0, dut.r_cnt}, 32'd0);

        // 3: 32nd bit together with frame end
        base = n_adds;
        send_bits(32'hFFFF_FFFF, 32, 1'b1);
        check("t3_cnt", {27'd0, dut.r_cnt}, 32'd0);
        step();
        check("t3_add", {31'd0, rxfifo_add}, 32'd1);
        check("t3_dat", rxfifo_dat_i, 32'hFFFF_FFFF);
        check("t3_last", {31'd0, rx_last}, 32'd1);
        check("t3_bits", {26'd0, rx_last_bits}, 32'd32);
        idle(3);
        check("t3_writes", n_adds - base, 1);

        // 4: second word dropped while FIFO is full
        base = n_adds;
        rxfifo_full = 1'b1;
        send_bits(32'hCAFE_0001, 32, 1'b0);
        check("t4_ovr_pre", {31'd0, overrun}, 32'd0);
        send_bits(32'h5555_AAAA, 32, 1'b0);
        check("t4_ovr", {31'd0, overrun}, 32'd1);
        idle(2);
        check("t4_held", n_adds - base, 0);
        rxfifo_full = 1'b0;
        step();
        check("t4_add", {31'd0, rxfifo_add}, 32'd1);
        check("t4_dat", rxfifo_dat_i, 32'hCAFE_0001);
        idle(4);
        check("t4_writes", n_adds - base, 1);
        check("t4_dat_keep", rxfifo_dat_i, 32'hCAFE_0001);
        check("t4_ovr_sticky", {31'd0, overrun}, 32'd1);
        wb_rst_i = 1'b1;
        step();
        wb_rst_i = 1'b0;
        check("t4_ovr_clr", {31'd0, overrun}, 32'd0);

        // 5: full released on the very edge word B completes
        base = n_adds;
        rxfifo_full = 1'b1;
        send_bits(32'h0F0F_1234, 32, 1'b0);
        send_bits(32'h8765_4321, 31, 1'b0);
        rxfifo_full = 1'b0;
        data_valid  = 1'b1;
        data_i      = 1'b1;
        step();
        data_valid  = 1'b0;
        data_i      = 1'b0;
        check("t5_addA", {31'd0, rxfifo_add}, 32'd1);
        check("t5_datA", rxfifo_dat_i, 32'h0F0F_1234);
        step();
        check("t5_addB", {31'd0, rxfifo_add}, 32'd1);
        check("t5_datB", rxfifo_dat_i, 32'h8765_4321);
        step();
        check("t5_add_off", {31'd0, rxfifo_add}, 32'd0);
        check("t5_ovr", {31'd0, overrun}, 32'd0);
        idle(2);
        check("t5_writes", n_adds - base, 2);

        // 6: restart with a word pending and a partial word collected
        for (int k = 0; k < 2; k++) begin
            rxfifo_full = 1'b1;
            send_bits(32'hDEAD_BEEF, 32, 1'b0);
            send_bits(32'h000A_BCDE, 20, 1'b0);
            if (k == 0) dc_restart = 1'b1;
            else        wb_rst_i = 1'b1;
            step();
            dc_restart = 1'b0;
            wb_rst_i   = 1'b0;
            check_zero(k == 0 ? "t6_restart" : "t6_reset");
            base = n_adds;
            rxfifo_full = 1'b0;
            idle(4);
            check("t6_no_write", n_adds - base, 0);
            send_bits(32'h1234_5678, 32, 1'b0);
            step();
            check("t6_add", {31'd0, rxfifo_add}, 32'd1);
            check("t6_dat", rxfifo_dat_i, 32'h1234_5678);
            check("t6_last", {31'd0, rx_last}, 32'd0);
            idle(2);
            check("t6_writes", n_adds - base, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irda_mir_rx_data_ctrl.md
Name: irda_mir_rx_data_ctrl

Overview:
Receive-side data controller for the MIR path. It takes de-stuffed serial bits from the MIR receive decoder, packs them LSB-first into 32-bit words, and pushes the words into the RX FIFO through a one-word holding register. At end of frame it flushes any partial word, tags the last word with its valid bit count, and flags overrun when the FIFO cannot keep up.

Parameters:
None. The word width is fixed at 32, matching the RX FIFO data width.

Ports:
clk  input  1  system clock; the only clock
wb_rst_i  input  1  reset, synchronous, active-high
dc_restart  input  1  synchronous restart; same effect as reset
mir_rx_enabled  input  1  MIR receive enabled; gates data_valid and frame_end
data_valid  input  1  one-cycle strobe: data_i carries a new de-stuffed bit
data_i  input  1  received bit, LSB of word first
frame_end  input  1  one-cycle pulse: closing flag detected, frame complete
rxfifo_full  input  1  RX FIFO cannot accept a word this cycle
rxfifo_add  output  1  one-cycle write strobe to RX FIFO
rxfifo_dat_i  output  32  word written to RX FIFO; valid while rxfifo_add=1
rx_last  output  1  valid with rxfifo_add; word is the final word of the frame
rx_last_bits  output  6  valid with rxfifo_add and rx_last; valid bits in word, 1..32
overrun  output  1  sticky; a completed word was dropped

Behaviour:
- Reset (wb_rst_i=1 or dc_restart=1 at a clock edge): sr=0, bit counter cnt=0, hold=0, pending=0, hold_last=0, hold_bits=0, rxfifo_add=0, rxfifo_dat_i=0, rx_last=0, rx_last_bits=0, overrun=0.
  - wb_rst_i has priority over dc_restart.
  - A pending word is discarded.
- Assembly, when mir_rx_enabled=1 and data_valid=1:
  - sr[cnt] <= data_i; cnt <= cnt+1 (cnt is 0..31, 5 bits).
  - On cnt==31 the word is complete: candidate word = {data_i, sr[30:0]}; cnt <= 0; sr <= 0.
- Flush, when mir_rx_enabled=1 and frame_end=1:
  - Candidate = sr with any same-cycle bit included; unfilled upper bits are 0.
  - Candidate is flagged last, with bits = number of bits collected including any same-cycle bit.
  - If 0 bits were collected, nothing is flushed and no last marker is generated.
  - cnt <= 0; sr <= 0.
  - A 32nd bit coinciding with frame_end gives a full word with last=1 and bits=32.
- mir_rx_enabled=0: data_valid and frame_end are ignored; sr and cnt hold. The output stage continues draining.
- Output stage, every non-reset edge:
  - If pending=1 and rxfifo_full=0: rxfifo_add <= 1; rxfifo_dat_i <= hold; rx_last <= hold_last; rx_last_bits <= hold_bits; pending <= 0.
  - Otherwise rxfifo_add <= 0 and rx_last <= 0. rxfifo_dat_i and rx_last_bits hold their values.
  - rxfifo_add is never high for more than one cycle per word.
- Holding register load, when a candidate exists:
  - Free if pending=0, or if pending is being drained at this same edge (pending=1 and rxfifo_full=0).
  - If free: hold <= candidate, hold_last, hold_bits (32 for a non-last word); pending <= 1. A load overrides the drain clear of pending.
  - If not free: the candidate is dropped and overrun <= 1. The held word is unaffected.
- Latency: data_valid for the 32nd bit in cycle N gives pending=1 in N+1 and rxfifo_add=1 in cycle N+2, provided rxfifo_full=0 in N+1.
- Sustained throughput: one word per 32 bit strobes. A bit strobe every cycle never overruns while rxfifo_full=0.
- overrun stays 1 until reset or dc_restart.

Test Plan:
1. Send 32 bits, word 0xA5C3_0F01 LSB-first, one strobe per cycle, rxfifo_full=0. Expect rxfifo_add pulse 2 cycles after the last strobe, rxfifo_dat_i=0xA5C3_0F01, rx_last=0.
2. Send 12 bits (value 0xABC) then frame_end. Expect rxfifo_dat_i=0x0000_0ABC, rx_last=1, rx_last_bits=12. A following frame_end with no bits produces no write.
3. Drive the 32nd bit in the same cycle as frame_end, word 0xFFFF_FFFF. Expect a single write with rx_last=1, rx_last_bits=32, cnt back to 0.
4. Hold rxfifo_full=1 while word A completes, then send word B completely. Expect B dropped, overrun=1. On releasing full, A is written once and no write of B occurs.
5. Hold rxfifo_full=1 over word A. Deassert it in exactly the cycle word B completes. Expect A written, then B written; no overrun.
6. Collect 20 bits with a word pending, then assert dc_restart. Expect no rxfifo_add afterwards and all outputs 0. Then 32 bits of 0x1234_5678 are written intact. Repeat the same check with wb_rst_i.
